// File: rtl/contactor_sequencer.sv
// Contactor sequencer: actuates one contactor at a time from synchronised SPI requests,
// confirms each transition against router feedback with a timeout, and keeps sticky faults.
module contactor_sequencer #(
    parameter int unsigned N_CONT     = 21,
    parameter int unsigned FB_TIMEOUT = 5000,
    parameter int unsigned GAP_CYCLES = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_CONT-1:0]   spi_requests,
    input  logic [2*N_CONT-1:0] router_feedback,
    input  logic                clear_errors,
    input  logic                force_open,
    output logic [N_CONT-1:0]   contactor_drive,
    output logic [N_CONT-1:0]   contactor_status,
    output logic [N_CONT-1:0]   fault_mask,
    output logic                feedback_timeout_error,
    output logic                invalid_request,
    output logic                busy
);

    localparam int unsigned IDX_W = (N_CONT > 1) ? $clog2(N_CONT) : 1;
    localparam int unsigned T_MAX = (FB_TIMEOUT > GAP_CYCLES) ? FB_TIMEOUT : GAP_CYCLES;
    localparam int unsigned TIM_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [TIM_W-1:0] FB_LAST  = TIM_W'(FB_TIMEOUT - 1);
    localparam logic [TIM_W-1:0] GAP_LAST = TIM_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CONT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT_FB,
        GAP
    } state_t;

    state_t state, state_n;

    logic [N_CONT-1:0]   req_m, req_s, req_d;
    logic [2*N_CONT-1:0] fb_m, fb_s;
    logic                clr_m, clr_s;

    logic [IDX_W-1:0] idx, idx_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [TIM_W-1:0] timer, timer_n;

    logic [N_CONT-1:0] drive_n, status_n, fault_n;
    logic              tout_n, inv_n;

    logic [N_CONT-1:0] pending;
    logic              found;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W:0]    scan_sum;
    logic [IDX_W-1:0]  scan_idx;
    logic [1:0]        fb_pair;
    logic [1:0]        fb_expect;
    logic              bad_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_m <= '0;
            req_s <= '0;
            req_d <= '0;
            fb_m  <= '0;
            fb_s  <= '0;
            clr_m <= 1'b0;
            clr_s <= 1'b0;
        end else begin
            req_m <= spi_requests;
            req_s <= req_m;
            req_d <= req_s;
            fb_m  <= router_feedback;
            fb_s  <= fb_m;
            clr_m <= clear_errors;
            clr_s <= clr_m;
        end
    end

    assign pending = (req_s ^ contactor_drive) & ~(req_s & fault_mask);

    // Round-robin pick: first pending index at or after rr_ptr, wrapping past N_CONT-1.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_CONT; k++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_sum >= (IDX_W+1)'(N_CONT)) begin
                scan_sum = scan_sum - (IDX_W+1)'(N_CONT);
            end
            scan_idx = scan_sum[IDX_W-1:0];
            if (!found && pending[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
    end

    assign fb_pair   = fb_s[{idx, 1'b0} +: 2];
    assign fb_expect = contactor_drive[idx] ? 2'b10 : 2'b01;
    assign bad_rise  = |(req_s & ~req_d & (fault_mask | {N_CONT{force_open}}));

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        rr_ptr_n = rr_ptr;
        timer_n  = timer;
        drive_n  = contactor_drive;
        status_n = contactor_status;
        fault_n  = fault_mask;
        tout_n   = feedback_timeout_error;
        inv_n    = invalid_request;

        if (force_open) begin
            drive_n  = '0;
            status_n = '0;
            timer_n  = '0;
            state_n  = GAP;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        idx_n   = sel;
                        state_n = DRIVE;
                    end
                end
                DRIVE: begin
                    drive_n[idx]  = req_s[idx];
                    status_n[idx] = 1'b0;
                    timer_n       = '0;
                    rr_ptr_n      = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    state_n       = WAIT_FB;
                end
                WAIT_FB: begin
                    if (fb_pair == fb_expect) begin
                        status_n[idx] = contactor_drive[idx];
                        timer_n       = '0;
                        state_n       = GAP;
                    end else if (timer == FB_LAST) begin
                        fault_n[idx]  = 1'b1;
                        drive_n[idx]  = 1'b0;
                        status_n[idx] = 1'b0;
                        tout_n        = 1'b1;
                        timer_n       = '0;
                        state_n       = GAP;
                    end else begin
                        timer_n = timer + TIM_W'(1);
                    end
                end
                GAP: begin
                    if (timer == GAP_LAST) begin
                        timer_n = '0;
                        state_n = IDLE;
                    end else begin
                        timer_n = timer + TIM_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        if (bad_rise) begin
            inv_n = 1'b1;
        end

        // Clear is applied last so it wins over a timeout or invalid request in the same cycle.
        if (clr_s) begin
            fault_n = '0;
            tout_n  = 1'b0;
            inv_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                  <= IDLE;
            idx                    <= '0;
            rr_ptr                 <= '0;
            timer                  <= '0;
            contactor_drive        <= '0;
            contactor_status       <= '0;
            fault_mask             <= '0;
            feedback_timeout_error <= 1'b0;
            invalid_request        <= 1'b0;
        end else begin
            state                  <= state_n;
            idx                    <= idx_n;
            rr_ptr                 <= rr_ptr_n;
            timer                  <= timer_n;
            contactor_drive        <= drive_n;
            contactor_status       <= status_n;
            fault_mask             <= fault_n;
            feedback_timeout_error <= tout_n;
            invalid_request        <= inv_n;
        end
    end

    assign busy = (state != IDLE);

endmodule
